// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS-32 control path and ALU control decoder.
package mips_pkg;

    typedef enum logic [3:0] {
        ST_FETCH  = 4'd0,
        ST_DECODE = 4'd1,
        ST_MEMADR = 4'd2,
        ST_MEMRD  = 4'd3,
        ST_MEMWB  = 4'd4,
        ST_MEMWR  = 4'd5,
        ST_EXEC   = 4'd6,
        ST_RWB    = 4'd7,
        ST_BRANCH = 4'd8,
        ST_JUMP   = 4'd9,
        ST_TRAP   = 4'd10
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // True in the last cycle of every legal instruction; a store retires only
    // once memory accepts the write.
    function automatic logic retires(state_t s, logic mem_ready);
        case (s)
            ST_MEMWB, ST_RWB, ST_BRANCH, ST_JUMP: retires = 1'b1;
            ST_MEMWR:                             retires = mem_ready;
            default:                              retires = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mips_ctrl_outdec.sv
// Combinational state -> datapath strobe decoder for the multicycle MIPS control.
module mips_ctrl_outdec
    import mips_pkg::*;
(
    input  state_t     state,
    input  logic       en,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       illegal_op
);

    // Moore decode of the strobes; everything is forced low while en (reset release) is 0.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_B;
        ALUOp       = ALUOP_ADD;
        PCSource    = PCSRC_ALU;
        illegal_op  = 1'b0;
        if (en) begin
            case (state)
                ST_FETCH: begin
                    MemRead = 1'b1;
                    ALUSrcB = SRCB_FOUR;
                    IRWrite = mem_ready;
                    PCWrite = mem_ready;
                end
                ST_DECODE: begin
                    ALUSrcB = SRCB_IMM_SH;
                end
                ST_MEMADR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = SRCB_IMM;
                end
                ST_MEMRD: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                ST_MEMWB: begin
                    RegWrite = 1'b1;
                    MemtoReg = 1'b1;
                end
                ST_MEMWR: begin
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                end
                ST_EXEC: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = ALUOP_FUNCT;
                end
                ST_RWB: begin
                    RegWrite = 1'b1;
                    RegDst   = 1'b1;
                end
                ST_BRANCH: begin
                    ALUSrcA     = 1'b1;
                    ALUOp       = ALUOP_SUB;
                    PCWriteCond = 1'b1;
                    PCSource    = PCSRC_ALUOUT;
                end
                ST_JUMP: begin
                    PCWrite  = 1'b1;
                    PCSource = PCSRC_JUMP;
                end
                ST_TRAP: begin
                    illegal_op = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS-32 datapath with retired-instruction counter.
module mips_multicycle_ctrl
    import mips_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemtoReg,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       PCSource,
    output logic             illegal_op,
    output logic [3:0]       state_o,
    output logic [CNT_W-1:0] instret
);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;

    // The branch decision is applied in the datapath (PCWriteCond & zero).
    logic unused_zero;
    assign unused_zero = zero;

    // State register and retired-instruction counter (wraps silently).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_FETCH;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (retires(state, mem_ready)) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Next-state sequencing; opcode is only looked at in DECODE and MEMADR.
    always_comb begin
        state_nxt = ST_FETCH;
        case (state)
            ST_FETCH:  state_nxt = mem_ready ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                case (opcode)
                    OP_RTYPE:     state_nxt = ST_EXEC;
                    OP_LW, OP_SW: state_nxt = ST_MEMADR;
                    OP_BEQ:       state_nxt = ST_BRANCH;
                    OP_J:         state_nxt = ST_JUMP;
                    default:      state_nxt = ST_TRAP;
                endcase
            end
            ST_MEMADR: state_nxt = (opcode == OP_SW) ? ST_MEMWR : ST_MEMRD;
            ST_MEMRD:  state_nxt = mem_ready ? ST_MEMWB : ST_MEMRD;
            ST_MEMWR:  state_nxt = mem_ready ? ST_FETCH : ST_MEMWR;
            ST_EXEC:   state_nxt = ST_RWB;
            default:   state_nxt = ST_FETCH;
        endcase
    end

    mips_ctrl_outdec u_outdec (
        .state       (state),
        .en          (rst_n),
        .mem_ready   (mem_ready),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .IRWrite     (IRWrite),
        .MemtoReg    (MemtoReg),
        .RegDst      (RegDst),
        .RegWrite    (RegWrite),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .ALUOp       (ALUOp),
        .PCSource    (PCSource),
        .illegal_op  (illegal_op)
    );

    assign state_o = rst_n ? 4'(state) : 4'd0;
    assign instret = cnt;

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
Main control FSM for the multicycle MIPS-32 datapath. It sequences each instruction through fetch, decode, execute, memory and writeback states, and drives all datapath strobes. It produces the 2-bit ALUOp consumed directly by the ALU control decoder: 00 = add, 01 = subtract, 10 = decode the funct field. It also handshakes with a unified instruction/data memory and keeps a count of retired instructions.

Parameters:
- CNT_W, 32, width of retired-instruction counter instret.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- opcode  in  6  instr[31:26] from the instruction register
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completed the current read/write this cycle
- PCWrite  out  1  unconditional PC load
- PCWriteCond  out  1  PC load if zero=1
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- IRWrite  out  1  instruction register load
- MemtoReg  out  1  register writeback source: 1 = MDR
- RegDst  out  1  destination select: 1 = rd, 0 = rt
- RegWrite  out  1  register file write
- ALUSrcA  out  1  0 = PC, 1 = A
- ALUSrcB  out  2  00 = B, 01 = 4, 10 = signext imm, 11 = signext imm<<2
- ALUOp  out  2  to ALU control decoder
- PCSource  out  2  00 = ALU, 01 = ALUOut, 10 = jump target
- illegal_op  out  1  one-cycle pulse on unsupported opcode
- state_o  out  4  current state, for debug
- instret  out  CNT_W  retired instruction count

Behaviour:
- States, with 4-bit encoding:
  - FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4, MEMWR = 5
  - EXEC = 6, RWB = 7, BRANCH = 8, JUMP = 9, TRAP = 10
  - Encodings 11–15 go to FETCH on the next cycle, with all outputs deasserted.
- Reset: on a clk edge with rst_n=0, state becomes FETCH and instret becomes 0. While rst_n=0, all outputs read 0: PCWrite, PCWriteCond, IRWrite, RegWrite, MemWrite, MemRead, illegal_op and the mux selects. Reset mid-instruction abandons the instruction with no strobe.
- Outputs are Moore, decoded from the state register, except the items gated by mem_ready and zero below. Any output not listed for a state is 0.
- FETCH:
  - Outputs: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00; IRWrite = PCWrite = mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE:
  - Outputs: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target precompute).
  - Next state by opcode: 000000 → EXEC; 100011 (lw) or 101011 (sw) → MEMADR; 000100 (beq) → BRANCH; 000010 (j) → JUMP; any other → TRAP.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Goes to MEMRD if lw, MEMWR if sw.
- MEMRD: MemRead=1, IorD=1. Holds until mem_ready=1, then goes to MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0. Goes to FETCH; instret +1.
- MEMWR: MemWrite=1, IorD=1. Holds until mem_ready=1, then goes to FETCH; instret +1 in the same cycle mem_ready=1.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Goes to RWB.
- RWB: RegWrite=1, RegDst=1, MemtoReg=0. Goes to FETCH; instret +1.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01. The PC actually loads only when zero=1. Goes to FETCH; instret +1 regardless of zero.
- JUMP: PCWrite=1, PCSource=10. Goes to FETCH; instret +1.
- TRAP: illegal_op=1 for exactly this one cycle. Goes to FETCH; instret is not incremented and no write strobe is asserted.
- Cycle counts with mem_ready=1 throughout:
  - lw: 5
  - sw: 4
  - R-type: 4
  - beq: 3
  - j: 3
  - illegal: 3
  - Each cycle with mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle.
- instret wraps modulo 2^CNT_W with no flag.
- MemRead and MemWrite are never both 1.
- opcode is sampled only in DECODE and MEMADR; the IR must remain stable from FETCH completion until the instruction ends.

Decomposition:
- Shared package mips_pkg holds:
  - the state typedef and encodings
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J
  - ALUOp constants ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10
  - ALUSrcB and PCSource select constants
- ALU control decoder imports the same ALUOp constants.
- One natural sub-module: mips_ctrl_outdec, the combinational state → strobe decoder. The next-state logic, the state register and the instret counter stay in the top.

Test Plan:
- lw, mem_ready=1: state_o sequence 0,1,2,3,4,0. RegWrite=1 and MemtoReg=1 only in cycle 5. instret 0→1.
- R-type, opcode=000000: states 0,1,6,7. ALUOp=10 in EXEC, RegDst=1 and RegWrite=1 in RWB, MemWrite=0 throughout.
- beq: run once with zero=1 and once with zero=0. Both: ALUOp=01 and PCWriteCond=1 in BRANCH, PCSource=01; both retire (instret +2 total).
- Memory stall: mem_ready held 0 for 3 cycles in FETCH, then sw with mem_ready held 0 for 2 cycles in MEMWR.
  - FETCH lasts 4 cycles with IRWrite=1 only in the last.
  - MemWrite=1 for 3 cycles.
  - instret increments once.
- Illegal opcode 111111: states 0,1,10,0. illegal_op is high for exactly 1 cycle, instret is unchanged, and no write strobe is asserted.
- rst_n=0 for 1 cycle while in MEMRD: all outputs are 0 during the reset cycle, then state=FETCH and instret=0. The next lw completes normally.
